// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner: row strobe, frame classify, debounce, key events into a 16-bit hex shift word.
// Latency: key_valid rises 1 cycle after the end of the DEBOUNCE-th matching frame. Optional KEYPAD_REPEAT_EN adds auto-repeat.
// Backpressure: none; key_valid is a single-cycle pulse that is never held or queued.
module keypad_scan #(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  col_n,
    input  logic        clr,
    output logic [3:0]  row_n,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_down,
    output logic [15:0] Hexs
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DB_W  = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);
    localparam logic [DB_W-1:0]  DB_FIRST = DB_W'(1);
    localparam bit DB_ONE = (DEBOUNCE == 1);

    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} state_t;

    logic [3:0]       col_s1_q, col_s1_d, col_s2_q, col_s2_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       row_idx_q, row_idx_d;
    logic [3:0]       row_n_q, row_n_d;
    logic [11:0]      frame_q, frame_d;
    state_t           state_q, state_d;
    logic [DB_W-1:0]  cnt_q, cnt_d;
    logic [3:0]       cand_q, cand_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_down_q, key_down_d;
    logic [15:0]      hexs_q, hexs_d;
`ifdef KEYPAD_REPEAT_EN
    logic [6:0]       rpt_q, rpt_d;
`endif

    logic        slot_end, frame_end, emit, is_none, is_one;
    logic [15:0] frame_full;
    logic [4:0]  n_low;
    logic [3:0]  low_idx;

    always_comb begin
        col_s1_d    = col_n;
        col_s2_d    = col_s1_q;
        div_d       = div_q;
        row_idx_d   = row_idx_q;
        row_n_d     = row_n_q;
        frame_d     = frame_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_down_d  = key_down_q;
        hexs_d      = clr ? 16'h0000 : hexs_q;
        emit        = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rpt_d       = (state_q == HELD) ? rpt_q : 7'd0;
`endif

        slot_end   = (div_q == DIV_LAST);
        frame_end  = slot_end && (row_idx_q == 2'd3);
        // bit {row,col} set means that key read as pressed in this frame
        frame_full = {~col_s2_q, frame_q};
        n_low      = 5'd0;
        low_idx    = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (frame_full[i]) begin
                n_low   = n_low + 5'd1;
                low_idx = 4'(i);
            end
        end
        is_none = (n_low == 5'd0);
        is_one  = (n_low == 5'd1);

        if (slot_end) begin
            div_d     = '0;
            row_idx_d = row_idx_q + 2'd1;
            row_n_d   = ~(4'b0001 << row_idx_d);
            case (row_idx_q)
                2'd0:    frame_d[3:0]  = ~col_s2_q;
                2'd1:    frame_d[7:4]  = ~col_s2_q;
                2'd2:    frame_d[11:8] = ~col_s2_q;
                default: frame_d       = frame_q;
            endcase
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        if (frame_end) begin
            case (state_q)
                IDLE: begin
                    if (is_one) begin
                        cand_d = low_idx;
                        cnt_d  = DB_FIRST;
                        if (DB_ONE) begin
                            state_d = HELD;
                            emit    = 1'b1;
                        end else begin
                            state_d = PRESS_CHK;
                        end
                    end
                end
                PRESS_CHK: begin
                    if (is_one && (low_idx == cand_q)) begin
                        cnt_d = cnt_q + DB_W'(1);
                        if (cnt_q == DB_LAST) begin
                            state_d = HELD;
                            emit    = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                HELD: begin
                    if (is_none) begin
                        cnt_d = DB_FIRST;
                        if (DB_ONE) begin
                            state_d    = IDLE;
                            key_down_d = 1'b0;
                        end else begin
                            state_d = RELEASE_CHK;
                        end
`ifdef KEYPAD_REPEAT_EN
                        rpt_d = 7'd0;
                    end else if (is_one && (low_idx == cand_q)) begin
                        // first repeat after 64 frames, then reload so the next lands 16 later
                        if (rpt_q == 7'd63) begin
                            emit  = 1'b1;
                            rpt_d = 7'd48;
                        end else begin
                            rpt_d = rpt_q + 7'd1;
                        end
                    end else begin
                        rpt_d = 7'd0;
`endif
                    end
                end
                RELEASE_CHK: begin
                    if (is_none) begin
                        cnt_d = cnt_q + DB_W'(1);
                        if (cnt_q == DB_LAST) begin
                            state_d    = IDLE;
                            key_down_d = 1'b0;
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (emit) begin
            key_valid_d = 1'b1;
            key_code_d  = cand_d;
            key_down_d  = 1'b1;
            hexs_d      = {(clr ? 12'h000 : hexs_q[11:0]), cand_d};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_s1_q    <= 4'hF;
            col_s2_q    <= 4'hF;
            div_q       <= '0;
            row_idx_q   <= 2'd0;
            row_n_q     <= 4'b1110;
            frame_q     <= 12'h000;
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
            hexs_q      <= 16'h0000;
`ifdef KEYPAD_REPEAT_EN
            rpt_q       <= 7'd0;
`endif
        end else begin
            col_s1_q    <= col_s1_d;
            col_s2_q    <= col_s2_d;
            div_q       <= div_d;
            row_idx_q   <= row_idx_d;
            row_n_q     <= row_n_d;
            frame_q     <= frame_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
            hexs_q      <= hexs_d;
`ifdef KEYPAD_REPEAT_EN
            rpt_q       <= rpt_d;
`endif
        end
    end

    assign row_n     = row_n_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;
    assign Hexs      = hexs_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan (SCAN_DIV=4, DEBOUNCE=2): a keypad model drives col_n from row_n, and a
// frame-level reference model of the debounce rules predicts every event, key_down, key_code and Hexs.
module tb_keypad_scan;

    localparam int DB         = 2;
    localparam int FRAME_CYC  = 16;

    logic        clk = 1'b0;
    logic        rst_n, clr;
    logic [3:0]  col_n, row_n, key_code;
    logic        key_valid, key_down;
    logic [15:0] Hexs;
    logic [15:0] keys;

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int p_obs = 0;

    // reference model state
    bit          m_held, m_down;
    int          m_run, m_rel, m_rpt, m_cand, m_events;
    logic [3:0]  m_code;
    logic [15:0] m_hexs;

    always #5 clk = ~clk;

    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && (row_n[r] === 1'b0)) col_n[c] = 1'b0;
    end

    keypad_scan #(.SCAN_DIV(4), .DEBOUNCE(DB)) dut (
        .clk(clk), .rst_n(rst_n), .col_n(col_n), .clr(clr),
        .row_n(row_n), .key_code(key_code), .key_valid(key_valid),
        .key_down(key_down), .Hexs(Hexs)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] onehot(input int k);
        logic [15:0] m;
        m = 16'h0001;
        return m << k;
    endfunction

    task automatic model_reset();
        m_held = 0; m_down = 0; m_run = 0; m_rel = 0; m_rpt = 0; m_cand = 0;
        m_code = 4'd0; m_hexs = 16'h0000;
    endtask

    // One frame of the debounce rules applied to a whole-frame key mask.
    task automatic model_frame(input logic [15:0] mask, input bit clr_now, output bit ev);
        int n, k;
        n = 0; k = 0; ev = 0;
        for (int i = 0; i < 16; i++) if (mask[i]) begin n++; k = i; end
        if (!m_held) begin
            if (n == 1 && m_run > 0 && k == m_cand) m_run++;
            else if (n == 1 && m_run == 0) begin m_run = 1; m_cand = k; end
            else m_run = 0;
            if (m_run >= DB) begin
                m_held = 1; m_run = 0; m_rel = 0; m_rpt = 0; ev = 1;
            end
        end else begin
            if (n == 0) begin
                m_rel++; m_rpt = 0;
                if (m_rel >= DB) begin m_held = 0; m_down = 0; m_rel = 0; end
            end else if (m_rel > 0) begin
                m_rel = 0;
            end else if (n == 1 && k == m_cand) begin
                m_rpt++;
`ifdef KEYPAD_REPEAT_EN
                if (m_rpt >= 64 && (m_rpt - 64) % 16 == 0) ev = 1;
`endif
            end else begin
                m_rpt = 0;
            end
        end
        if (ev) begin
            m_events++;
            m_code = 4'(m_cand);
            m_down = 1;
            m_hexs = clr_now ? {12'h000, 4'(m_cand)} : {m_hexs[11:0], 4'(m_cand)};
        end else if (clr_now) begin
            m_hexs = 16'h0000;
        end
    endtask

    // Holds mask for one whole frame; clr is pulsed on edge clr_tick (1..16, 0 = none).
    task automatic run_frame(input logic [15:0] mask, input int clr_tick);
        bit ev;
        keys = mask;
        for (int t = 1; t <= FRAME_CYC; t++) begin
            clr = (t == clr_tick);
            @(posedge clk);
            #1;
            clr = 1'b0;
            p_obs += int'(key_valid);
            if (t < FRAME_CYC) begin
                chk("key_valid_idle", 16'(key_valid), 16'h0);
                if (t == clr_tick) begin
                    m_hexs = 16'h0000;
                    chk("hexs_after_clr", Hexs, m_hexs);
                end
            end else begin
                model_frame(mask, t == clr_tick, ev);
                chk("key_valid_frame", 16'(key_valid), 16'(ev));
                chk("key_down", 16'(key_down), 16'(m_down));
                chk("key_code", 16'(key_code), 16'(m_code));
                chk("hexs", Hexs, m_hexs);
            end
        end
    endtask

    task automatic press_release(input int k, input int n_press, input int n_rel);
        for (int i = 0; i < n_press; i++) run_frame(onehot(k), 0);
        for (int i = 0; i < n_rel; i++) run_frame(16'h0000, 0);
    endtask

    initial begin
        int          kind, len, a, b, ct;
        logic [15:0] mask;

        rst_n = 1'b0; clr = 1'b0; keys = 16'h0000;
        model_reset();
        m_events = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_row_n", 16'(row_n), 16'h000E);
        chk("rst_key_valid", 16'(key_valid), 16'h0);
        chk("rst_key_down", 16'(key_down), 16'h0);
        chk("rst_key_code", 16'(key_code), 16'h0);
        chk("rst_hexs", Hexs, 16'h0000);
        rst_n = 1'b1;

        // single key (row2,col1) = 9, then release
        p_obs = 0;
        press_release(9, 3, 0);
        chk("k9_code", 16'(key_code), 16'h0009);
        chk("k9_hexs", Hexs, 16'h0009);
        chk("k9_down", 16'(key_down), 16'h1);
        press_release(9, 0, 2);
        chk("k9_released", 16'(key_down), 16'h0);
        chk("k9_one_pulse", 16'(p_obs), 16'd1);

        // one-frame glitch never reaches HELD
        p_obs = 0;
        press_release(5, 1, 2);
        chk("glitch_no_pulse", 16'(p_obs), 16'd0);

        // ghosting: two keys in the same row
        run_frame(16'h0009, 0);
        run_frame(16'h0009, 0);
        run_frame(16'h0009, 0);
        run_frame(16'h0000, 0);
        chk("multi_no_pulse", 16'(p_obs), 16'd0);
        chk("multi_hexs", Hexs, 16'h0009);

        // five keys, clr mid-frame, clr coincident with an accept
        for (int k = 1; k <= 5; k++) press_release(k, 3, 2);
        chk("seq_hexs", Hexs, 16'h2345);
        run_frame(16'h0000, 6);
        chk("clr_hexs", Hexs, 16'h0000);
        run_frame(onehot(7), 0);
        run_frame(onehot(7), 16);
        chk("clr_shift_hexs", Hexs, 16'h0007);
        press_release(7, 0, 2);

        // long hold of key A
        p_obs = 0;
        press_release(10, 100, 2);
`ifdef KEYPAD_REPEAT_EN
        chk("hold_pulses", 16'(p_obs), 16'd4);
        chk("hold_hexs", Hexs, 16'hAAAA);
`else
        chk("hold_pulses", 16'(p_obs), 16'd1);
        chk("hold_hexs", Hexs, 16'h007A);
`endif

        // reset while a key is held, mid-frame
        press_release(3, 2, 0);
        chk("pre_rst_down", 16'(key_down), 16'h1);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_row_n", 16'(row_n), 16'h000E);
        chk("midrst_key_valid", 16'(key_valid), 16'h0);
        chk("midrst_key_down", 16'(key_down), 16'h0);
        chk("midrst_hexs", Hexs, 16'h0000);
        keys = 16'h0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // randomized frame sequences against the model
        for (int s = 0; s < 60; s++) begin
            kind = int'($urandom_range(0, 3));
            len  = int'($urandom_range(1, 4));
            a    = int'($urandom_range(0, 15));
            b    = (a + int'($urandom_range(1, 15))) % 16;
            case (kind)
                0:       mask = 16'h0000;
                3:       mask = onehot(a) | onehot(b);
                default: mask = onehot(a);
            endcase
            for (int f = 0; f < len; f++) begin
                ct = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 16)) : 0;
                run_frame(mask, ct);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
